// File: rtl/msg_sequencer_if.sv
// ============================================================================
//  Module      : msg_sequencer_if
//  Description : Avalon-ST source bundle between msg_sequencer and the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface msg_sequencer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_sop;
    logic              src_eop;

    modport master (
        output src_data,
        output src_valid,
        output src_sop,
        output src_eop,
        input  src_ready
    );

    modport slave (
        input  src_data,
        input  src_valid,
        input  src_sop,
        input  src_eop,
        output src_ready
    );
endinterface

`default_nettype wire

// File: rtl/msg_sequencer.sv
// ============================================================================
//  Module      : msg_sequencer
//  Description : Emits one numbered test message per start, then waits for the
//                remover count to match or times out. Optional start_overrun
//                flag is enabled by defining MSG_SEQ_OVERRUN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msg_sequencer #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 msg_start,
    input  wire logic [7:0]           msg_words,
    input  wire logic [7:0]           msg_words_in_remover,
    msg_sequencer_if.master           src,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout,
`ifdef MSG_SEQ_OVERRUN_EN
    output logic                      start_overrun,
`endif
    output logic [7:0]                words_sent
);

    localparam int c_TCNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [7:0]          r_msg_id;
    logic [7:0]          r_n;
    logic [7:0]          r_index;
    logic [c_TCNT_W-1:0] r_tcnt;
    logic [7:0]          r_words_sent;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_valid;
    logic                r_sop;
    logic                r_eop;
    logic [DATA_W-1:0]   r_data;
`ifdef MSG_SEQ_OVERRUN_EN
    logic                r_overrun;
`endif

    logic                w_xfer;
    logic [7:0]          w_idx_nxt;

    assign w_xfer    = r_valid & src.src_ready;
    assign w_idx_nxt = r_index + 8'd1;

    // Message id in the top byte, word index in the bottom byte, zeros between.
    function automatic logic [DATA_W-1:0] f_word(input logic [7:0] id, input logic [7:0] idx);
        logic [DATA_W-1:0] w;
        w               = '0;
        w[DATA_W-1 -: 8] = id;
        w[7:0]          = idx;
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_msg_id     <= 8'd0;
            r_n          <= 8'd0;
            r_index      <= 8'd0;
            r_tcnt       <= '0;
            r_words_sent <= 8'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_valid      <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_data       <= '0;
`ifdef MSG_SEQ_OVERRUN_EN
            r_overrun    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (msg_start) begin
                        r_err        <= 1'b0;
                        r_words_sent <= 8'd0;
                        r_index      <= 8'd0;
                        r_n          <= msg_words;
                        if (msg_words == 8'd0) begin
                            r_done   <= 1'b1;
                            r_msg_id <= r_msg_id + 8'd1;
                        end else begin
                            r_state <= S_SEND;
                            r_busy  <= 1'b1;
                            r_valid <= 1'b1;
                            r_sop   <= 1'b1;
                            r_eop   <= (msg_words == 8'd1);
                            r_data  <= f_word(r_msg_id, 8'd0);
                        end
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_words_sent <= r_words_sent + 8'd1;
                        if (r_eop) begin
                            r_valid <= 1'b0;
                            r_sop   <= 1'b0;
                            r_eop   <= 1'b0;
                            r_tcnt  <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_index <= w_idx_nxt;
                            r_sop   <= 1'b0;
                            r_eop   <= (w_idx_nxt == r_n - 8'd1);
                            r_data  <= f_word(r_msg_id, w_idx_nxt);
                        end
                    end
                end
                S_DRAIN: begin
                    // A count match in the final timeout cycle still counts as success.
                    if (msg_words_in_remover == r_n) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_tcnt == c_TCNT_LAST) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_msg_id <= r_msg_id + 8'd1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
`ifdef MSG_SEQ_OVERRUN_EN
            // Later assignment gives a fresh overrun priority over the clear.
            if ((r_state == S_IDLE) && msg_start)
                r_overrun <= 1'b0;
            if (msg_start && r_busy)
                r_overrun <= 1'b1;
`endif
        end
    end

    assign src.src_data  = r_data;
    assign src.src_valid = r_valid;
    assign src.src_sop   = r_sop;
    assign src.src_eop   = r_eop;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err_timeout   = r_err;
    assign words_sent    = r_words_sent;
`ifdef MSG_SEQ_OVERRUN_EN
    assign start_overrun = r_overrun;
`endif

endmodule

`default_nettype wire

// File: tb/tb_msg_sequencer.sv
// ============================================================================
//  Module      : tb_msg_sequencer
//  Description : Directed self-checking bench for msg_sequencer (TIMEOUT_CYC=20).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msg_sequencer;

    localparam int c_TO = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       msg_start = 1'b0;
    logic [7:0] msg_words = 8'd0;
    logic [7:0] rem = 8'd0;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic [7:0] words_sent;
`ifdef MSG_SEQ_OVERRUN_EN
    logic       start_overrun;
`endif

    int total = 0;
    int bad   = 0;
    int cyc;
    int exp_idx;
    int pat [6] = '{1, 0, 0, 1, 0, 1};

    msg_sequencer_if #(.DATA_W(32)) sif ();

    msg_sequencer #(
        .DATA_W      (32),
        .TIMEOUT_CYC (c_TO)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .msg_start            (msg_start),
        .msg_words            (msg_words),
        .msg_words_in_remover (rem),
        .src                  (sif.master),
        .busy                 (busy),
        .done                 (done),
        .err_timeout          (err_timeout),
`ifdef MSG_SEQ_OVERRUN_EN
        .start_overrun        (start_overrun),
`endif
        .words_sent           (words_sent)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int id, input int idx);
        return (32'(id) << 24) | 32'(idx);
    endfunction

    task automatic start_msg(input logic [7:0] n);
        msg_words = n;
        msg_start = 1'b1;
        @(negedge clk);
        msg_start = 1'b0;
        msg_words = 8'd0;
    endtask

    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_value("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        sif.src_ready = 1'b1;
        @(negedge clk);
        check_value("rst_valid", 32'(sif.src_valid), 0);
        check_value("rst_data", sif.src_data, 0);
        check_value("rst_sop_eop", {30'd0, sif.src_sop, sif.src_eop}, 0);
        check_value("rst_busy_done_err", {29'd0, busy, done, err_timeout}, 0);
        check_value("rst_words_sent", 32'(words_sent), 0);
`ifdef MSG_SEQ_OVERRUN_EN
        check_value("rst_overrun", 32'(start_overrun), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // 4 words back to back, msg_id 0
        rem = 8'd0;
        start_msg(8'd4);
        for (int k = 0; k < 4; k++) begin
            check_value("a_valid", 32'(sif.src_valid), 1);
            check_value("a_data", sif.src_data, exp_word(0, k));
            check_value("a_sop", 32'(sif.src_sop), 32'(k == 0));
            check_value("a_eop", 32'(sif.src_eop), 32'(k == 3));
            check_value("a_busy", 32'(busy), 1);
            @(negedge clk);
        end
        check_value("a_valid_after", 32'(sif.src_valid), 0);
        check_value("a_words_sent", 32'(words_sent), 4);
        check_value("a_no_early_done", 32'(done), 0);
        rem = 8'd4;
        @(negedge clk);
        check_value("a_done", 32'(done), 1);
        check_value("a_err", 32'(err_timeout), 0);
        @(negedge clk);
        check_value("a_done_once", 32'(done), 0);
        check_value("a_idle", 32'(busy), 0);
        check_value("a_words_hold", 32'(words_sent), 4);

        // 3 words with stalls, msg_id 1
        rem = 8'd0;
        start_msg(8'd3);
        exp_idx = 0;
        for (int c = 0; c < 6; c++) begin
            check_value("b_valid", 32'(sif.src_valid), 1);
            check_value("b_data", sif.src_data, exp_word(1, exp_idx));
            check_value("b_sop", 32'(sif.src_sop), 32'(exp_idx == 0));
            check_value("b_eop", 32'(sif.src_eop), 32'(exp_idx == 2));
            sif.src_ready = pat[c][0];
            if (pat[c] != 0) exp_idx++;
            @(negedge clk);
        end
        sif.src_ready = 1'b1;
        check_value("b_valid_after", 32'(sif.src_valid), 0);
        check_value("b_words_sent", 32'(words_sent), 3);
        rem = 8'd3;
        @(negedge clk);
        check_value("b_done", 32'(done), 1);
        @(negedge clk);

        // reset between messages resets msg_id
        rst_n = 1'b0;
        @(negedge clk);
        check_value("r_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2 words, remover stuck at 1: timeout, msg_id 0
        rem = 8'd1;
        start_msg(8'd2);
        check_value("c_data0", sif.src_data, exp_word(0, 0));
        @(negedge clk);
        check_value("c_eop", 32'(sif.src_eop), 1);
        check_value("c_data1", sif.src_data, exp_word(0, 1));
        @(negedge clk);
        check_value("c_valid_after", 32'(sif.src_valid), 0);
        wait_done(2 * c_TO, cyc);
        check_value("c_timeout_latency", 32'(cyc), c_TO);
        check_value("c_err", 32'(err_timeout), 1);
        @(negedge clk);
        check_value("c_err_sticky", 32'(err_timeout), 1);
        check_value("c_idle", 32'(busy), 0);

        // 1 word: clears err, match on the final timeout cycle wins
        rem = 8'd0;
        start_msg(8'd1);
        check_value("d_err_clear", 32'(err_timeout), 0);
        check_value("d_data", sif.src_data, exp_word(1, 0));
        check_value("d_sop_eop", {30'd0, sif.src_sop, sif.src_eop}, 3);
        @(negedge clk);
        check_value("d_valid_after", 32'(sif.src_valid), 0);
        check_value("d_words_sent", 32'(words_sent), 1);
        repeat (c_TO - 1) @(negedge clk);
        check_value("d_no_early_done", 32'(done), 0);
        rem = 8'd1;
        @(negedge clk);
        check_value("d_done", 32'(done), 1);
        check_value("d_match_wins", 32'(err_timeout), 0);
        @(negedge clk);

        // zero-word start, msg_id 2 -> 3
        start_msg(8'd0);
        check_value("e_done", 32'(done), 1);
        check_value("e_valid", 32'(sif.src_valid), 0);
        check_value("e_busy", 32'(busy), 0);
        @(negedge clk);
        check_value("e_done_once", 32'(done), 0);
        check_value("e_valid2", 32'(sif.src_valid), 0);

        // 5 words with a start pulse mid-message, msg_id 3
        rem = 8'd0;
        start_msg(8'd5);
`ifdef MSG_SEQ_OVERRUN_EN
        check_value("f_overrun_clear", 32'(start_overrun), 0);
`endif
        for (int k = 0; k < 5; k++) begin
            check_value("f_valid", 32'(sif.src_valid), 1);
            check_value("f_data", sif.src_data, exp_word(3, k));
            check_value("f_eop", 32'(sif.src_eop), 32'(k == 4));
            msg_start = (k == 2);
            msg_words = (k == 2) ? 8'd7 : 8'd0;
            @(negedge clk);
        end
        msg_start = 1'b0;
        msg_words = 8'd0;
        check_value("f_valid_after", 32'(sif.src_valid), 0);
        check_value("f_words_sent", 32'(words_sent), 5);
`ifdef MSG_SEQ_OVERRUN_EN
        check_value("f_overrun_set", 32'(start_overrun), 1);
`endif
        rem = 8'd5;
        @(negedge clk);
        check_value("f_done", 32'(done), 1);
        @(negedge clk);
`ifdef MSG_SEQ_OVERRUN_EN
        check_value("f_overrun_sticky", 32'(start_overrun), 1);
`endif

        // reset during the third word of 6, msg_id 4
        rem = 8'd0;
        start_msg(8'd6);
        check_value("g_data0", sif.src_data, exp_word(4, 0));
`ifdef MSG_SEQ_OVERRUN_EN
        check_value("g_overrun_clear", 32'(start_overrun), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        check_value("g_data2", sif.src_data, exp_word(4, 2));
        check_value("g_valid2", 32'(sif.src_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("g_async_valid", 32'(sif.src_valid), 0);
        check_value("g_async_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_value("g_no_done", 32'(done), 0);
            check_value("g_no_busy", 32'(busy), 0);
            check_value("g_no_valid", 32'(sif.src_valid), 0);
        end
        rem = 8'd1;
        start_msg(8'd1);
        check_value("g_msg_id_reset", sif.src_data, exp_word(0, 0));
        @(negedge clk);
        @(negedge clk);
        check_value("g_final_done", 32'(done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/msg_sequencer.md
Name: msg_sequencer

Overview:
- Sequences one AES test message per start command from the register block.
- On msg_start it latches the word count and emits that many words on an Avalon-ST source into the adder/AES/remover chain.
- It then waits for the remover's word count to match, and reports completion or timeout.
- Sits between the MM register controller (msg_start, msg_words) and the streaming datapath.

Parameters:
- DATA_W, 32, source data width; minimum 16.
- TIMEOUT_CYC, 1024, number of DRAIN cycles allowed before a timeout is declared; minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- msg_start  in  1  single-cycle start pulse
- msg_words  in  8  words in the message; sampled only when msg_start=1 in IDLE
- msg_words_in_remover  in  8  words counted by the remover
- src_data  out  DATA_W  word payload
- src_valid  out  1  source valid
- src_ready  in  1  sink ready
- src_sop  out  1  first word of the message
- src_eop  out  1  last word of the message
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- err_timeout  out  1  sticky timeout flag; cleared by the next accepted start
- words_sent  out  8  words accepted by the sink in the current message

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All outputs are registered.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Internal msg_id 0, latched count N 0, index 0, timeout counter 0.
- Reset asserted mid-message: src_valid drops immediately (asynchronously); the partial message is abandoned with no eop and no done.
- State IDLE:
  - msg_start=1 with msg_words=0: done pulses the next cycle, err_timeout clears, msg_id increments, no stream traffic, stays in IDLE.
  - msg_start=1 with msg_words>0: latch N, clear words_sent and err_timeout, index=0; go to SEND. src_valid=1 from the next cycle.
- State SEND:
  - src_data = {msg_id[7:0], zero pad, index[7:0]}. msg_id sits in the top 8 bits, index in the low 8 bits.
  - src_sop=1 when index==0; src_eop=1 when index==N-1. For N=1 both are high on the same word.
  - A transfer occurs when src_valid and src_ready are both high; on a transfer, index and words_sent increment.
  - While src_ready=0, src_valid, src_data, src_sop and src_eop are held stable.
  - On the transfer of the eop word: src_valid=0 on the next cycle, timeout counter=0, go to DRAIN.
  - No bubbles: with src_ready held high, N words take exactly N cycles.
- State DRAIN:
  - Each cycle: if msg_words_in_remover==N, go to DONE.
  - Otherwise, if the timeout counter == TIMEOUT_CYC-1, set err_timeout and go to DONE.
  - Otherwise increment the timeout counter.
  - If the count match and the timeout occur in the same cycle, the match wins and err_timeout stays 0.
- State DONE: done=1 for exactly one cycle, msg_id increments (wraps 255->0), return to IDLE. busy=0 from the next cycle.
- Start-to-first-valid latency is 1 cycle. A new start is accepted at the earliest on the cycle after done.
- msg_start while busy is ignored; N, msg_id and the stream are unaffected.
- words_sent holds its final value until the next accepted start.
- msg_words=255 is legal; index is 8-bit and does not wrap within a message.

Optional Feature:
- Macro: MSG_SEQ_OVERRUN_EN
- Defined:
  - Adds output start_overrun (out, 1).
  - start_overrun is a sticky flag set when msg_start=1 while busy=1. Reset value 0.
  - Cleared only by an accepted start in IDLE; if that start also coincides with a new overrun condition, set wins.
  - The ignored start still has no other effect.
- Undefined: the port does not exist, and starts while busy are silently dropped.

Test Plan:
- Start with msg_words=4, src_ready=1, remover count reaching 4 two cycles after eop:
  - 4 consecutive words with data low bytes 0,1,2,3 and msg_id 0.
  - sop on word 0, eop on word 3.
  - done pulses once; words_sent=4; err_timeout=0.
- Start with msg_words=3, src_ready toggling 1,0,0,1,0,1:
  - Data is held stable during stalls; exactly 3 transfers occur.
  - eop only on index 2; done after the remover count reaches 3.
- Start with msg_words=2, remover count stuck at 1:
  - After eop, err_timeout=1 and done pulses exactly TIMEOUT_CYC DRAIN cycles later.
  - A following start with 1 word clears err_timeout, and that word carries msg_id=1.
- Start with msg_words=0: done pulses on the next cycle, src_valid stays 0, msg_id increments.
- msg_start pulsed mid-SEND of a 5-word message:
  - The message still carries exactly 5 words.
  - With MSG_SEQ_OVERRUN_EN defined, start_overrun=1 until the next accepted start.
- rst_n asserted during the third word of 6: src_valid=0 immediately; after release busy=0, no done, msg_id=0.
